// File: rtl/sample_pacer.sv
// Paced sample feeder: buffers valid/ready input samples in a small FIFO and releases
// exactly one single-cycle strobe per SAMP_DIV clocks to a filter without back-pressure.
module sample_pacer #(
  parameter int DW        = 24,
  parameter int DEPTH     = 8,
  parameter int SAMP_DIV  = 10,
  parameter int PRIME_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DW-1:0]            data_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun,
  output logic [15:0]              underrun_cnt,
  input  logic                     clr_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SAMP_DIV > 2) ? $clog2(SAMP_DIV) : 1;

  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_PRIME = (AW+1)'(PRIME_LVL);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SAMP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            tick;
  logic            empty;

  // Everything below is decoded from registered occupancy, so a sample pushed this
  // cycle cannot be popped until the next one.
  assign empty   = (fifo_level == '0);
  assign s_ready = (fifo_level < LVL_FULL) && !flush;
  assign push    = s_valid && s_ready;
  assign tick    = en && (state == RUN) && (cnt == CNT_LAST);
  assign pop     = tick && !empty && !flush;

  // NOTE: the sample storage has no reset; occupancy and pointers alone decide what is
  // valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers update
  // from the same pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Pacing FSM: the divider only runs in RUN, and dropping en always restarts priming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!en) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= PRIME;
          cnt   <= '0;
        end
        PRIME: begin
          if (fifo_level >= LVL_PRIME) state <= RUN;
          cnt <= '0;
        end
        RUN: begin
          cnt <= tick ? '0 : cnt + CW'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= pop;
      data_out  <= pop ? mem[rd_ptr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (clr_underrun) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (tick && empty) begin
      underrun <= 1'b1;
      if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sample_pacer.sv
// Bench for sample_pacer: directed sequence with random sample data, compared every
// cycle against a queue-based model of the pacing rules.
module tb_sample_pacer;

  localparam int DW        = 24;
  localparam int DEPTH     = 8;
  localparam int SAMP_DIV  = 10;
  localparam int PRIME_LVL = 2;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          clr_underrun = 1'b0;
  logic          s_ready;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [LW-1:0] fifo_level;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  always #5 clk = ~clk;

  sample_pacer #(
    .DW(DW), .DEPTH(DEPTH), .SAMP_DIV(SAMP_DIV), .PRIME_LVL(PRIME_LVL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .data_out(data_out), .valid_out(valid_out), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .clr_underrun(clr_underrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: the FIFO is a queue, pacing is "cycles since RUN was entered".
  logic [DW-1:0] q[$];
  int            run_cycles = -1;
  bit            armed      = 1'b0;
  bit            m_valid    = 1'b0;
  logic [DW-1:0] m_data     = '0;
  bit            m_und      = 1'b0;
  int            m_und_cnt  = 0;
  bit            last_acc   = 1'b0;
  bit            dut_acc    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("valid_out", valid_out, m_valid);
    check("data_out", data_out, m_data);
    check("fifo_level", fifo_level, q.size());
    check("s_ready", s_ready, (q.size() < DEPTH) && !flush);
    check("underrun", underrun, m_und);
    check("underrun_cnt", underrun_cnt, m_und_cnt);
  endtask

  task automatic model_reset();
    q.delete();
    run_cycles = -1;
    armed      = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_und      = 1'b0;
    m_und_cnt  = 0;
  endtask

  // One clock: evaluate the rules on pre-edge inputs, advance, then compare.
  task automatic cycle();
    int sz;
    bit ready, tick, pop;
    sz       = q.size();
    ready    = (sz < DEPTH) && !flush;
    tick     = en && (run_cycles >= 0) && (run_cycles % SAMP_DIV == SAMP_DIV - 1);
    pop      = tick && (sz > 0) && !flush;
    last_acc = s_valid && ready;
    dut_acc  = s_valid && s_ready;
    @(posedge clk);
    m_valid = pop;
    m_data  = pop ? q[0] : '0;
    if (clr_underrun) begin
      m_und     = 1'b0;
      m_und_cnt = 0;
    end else if (tick && sz == 0) begin
      m_und = 1'b1;
      if (m_und_cnt < 65535) m_und_cnt++;
    end
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (last_acc) q.push_back(s_data);
    end
    if (!en) begin
      run_cycles = -1;
      armed      = 1'b0;
    end else if (run_cycles >= 0) run_cycles++;
    else if (armed) begin
      if (sz >= PRIME_LVL) run_cycles = 0;
    end else armed = 1'b1;
    cyc++;
    #1;
    check_all();
  endtask

  task automatic wait_pulse(input string tag, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (valid_out === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check({tag, "_pulse_seen"}, at >= 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            p [5];
    int            p_at, t0, idx;
    bit            got;
    logic [DW-1:0] d [9];
    logic [DW-1:0] first_val;

    // 1: reset values
    #1;
    check_all();
    check("t1_s_ready", s_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // 2: prime with 1..4, then four paced pulses and an underrun on the fifth tick
    for (int i = 1; i <= 4; i++) begin
      s_data  = DW'(i);
      s_valid = 1'b1;
      cycle();
    end
    s_valid = 1'b0;
    en = 1'b1;
    t0 = cyc;
    wait_pulse("t2_p1", 30, p[1]);
    check("t2_first_delay", p[1] - t0, SAMP_DIV + 2);
    check("t2_d1", data_out, 1);
    for (int k = 2; k <= 4; k++) begin
      wait_pulse("t2_pk", 15, p[k]);
      check("t2_spacing", p[k] - p[k-1], SAMP_DIV);
      check("t2_dk", data_out, k);
    end
    repeat (SAMP_DIV) cycle();
    check("t2_underrun", underrun, 1);
    check("t2_underrun_cnt", underrun_cnt, 1);
    en = 1'b0;
    clr_underrun = 1'b1;
    cycle();
    clr_underrun = 1'b0;
    check("t2_cleared", underrun_cnt, 0);

    // 3: nine back-to-back samples into an 8-deep FIFO while paused
    for (int i = 0; i < 9; i++) d[i] = DW'($urandom());
    idx = 0;
    s_valid = 1'b1;
    s_data  = d[0];
    repeat (12) begin
      cycle();
      if (last_acc && idx < 8) begin
        idx++;
        s_data = d[idx];
      end
    end
    check("t3_level_full", fifo_level, 8);
    check("t3_ready_low", s_ready, 0);
    check("t3_accepted", idx, 8);
    en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle();
      got = dut_acc;
    end
    check("t3_ninth_accepted", got, 1);
    s_valid = 1'b0;

    // 4: drop en for three clocks mid-RUN, then re-prime
    wait_pulse("t4_pre", 2 * SAMP_DIV, p_at);
    en = 1'b0;
    repeat (3) begin
      cycle();
      check("t4_no_pulse", valid_out, 0);
    end
    en = 1'b1;
    t0 = cyc;
    wait_pulse("t4_post", 30, p_at);
    check("t4_restart_delay", p_at - t0, SAMP_DIV + 2);
    repeat (7 * SAMP_DIV) cycle();
    en = 1'b0;

    // 5: flush a full FIFO while the source is still offering a sample
    clr_underrun = 1'b1;
    cycle();
    clr_underrun = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 12 && q.size() < DEPTH; i++) begin
      s_data = DW'($urandom());
      cycle();
    end
    check("t5_full", fifo_level, 8);
    en = 1'b1;
    repeat (3) cycle();
    s_data = DW'($urandom());
    flush  = 1'b1;
    #1;
    check("t5_ready_during_flush", s_ready, 0);
    cycle();
    flush   = 1'b0;
    s_valid = 1'b0;
    check("t5_level_after_flush", fifo_level, 0);
    repeat (SAMP_DIV - 1) cycle();
    check("t5_underrun", underrun, 1);
    check("t5_underrun_cnt", underrun_cnt, 1);

    // 6: asynchronous reset while a pulse is on the output
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = DW'($urandom());
      cycle();
    end
    s_valid = 1'b0;
    wait_pulse("t6_pre", 2 * SAMP_DIV, p_at);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_valid_async", valid_out, 0);
    check("t6_data_async", data_out, 0);
    check("t6_level_async", fifo_level, 0);
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;
    repeat (15) cycle();
    check("t6_level_idle", fifo_level, 0);
    check("t6_cnt_idle", underrun_cnt, 0);
    first_val = DW'($urandom());
    s_valid = 1'b1;
    s_data  = first_val;
    cycle();
    s_data = DW'($urandom());
    cycle();
    s_valid = 1'b0;
    wait_pulse("t6_post", 20, p_at);
    check("t6_first_data", data_out, first_val);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
